// File: rtl/write_back_unit_pkg.sv
// Shared types and defaults for the write-back stage.
package write_back_unit_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        NO_WRITE_BACK   = 2'd0,
        WRITE_BACK_PC   = 2'd1,
        WRITE_BACK_OUT  = 2'd2,
        WRITE_BACK_LOAD = 2'd3
    } write_back_op_t;

    typedef enum logic [1:0] {
        LOAD_BYTE = 2'd0,
        LOAD_HALF = 2'd1,
        LOAD_WORD = 2'd2
    } load_size_t;

    typedef enum logic {
        NO_REG_DATA    = 1'b0,
        WRITE_REG_DATA = 1'b1
    } reg_file_op_t;

endpackage

// File: rtl/write_back_unit_load_align.sv
// Combinational load extraction: selects byte/half/word from an aligned word and extends to XLEN.
module load_align
    import write_back_unit_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
)
(
    input  logic [XLEN-1:0] load_data,
    input  logic [1:0]      byte_offset,
    input  load_size_t      load_size,
    input  logic            load_unsigned,
    output logic [XLEN-1:0] load_value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        fill;
    logic [31:0] word_ext;

    assign byte_sel = load_data[{byte_offset, 3'b000} +: 8];
    assign half_sel = load_data[{byte_offset[1], 4'b0000} +: 16];

    always_comb begin
        fill     = 1'b0;
        word_ext = load_data[31:0];
        case (load_size)
            LOAD_BYTE: begin
                fill     = ~load_unsigned & byte_sel[7];
                word_ext = {{24{fill}}, byte_sel};
            end
            LOAD_HALF: begin
                fill     = ~load_unsigned & half_sel[15];
                word_ext = {{16{fill}}, half_sel};
            end
            default: begin
                fill     = ~load_unsigned & load_data[31];
                word_ext = load_data[31:0];
            end
        endcase
    end

    // XLEN == 32 needs no fill above bit 31; a zero-width replication is illegal.
    generate
        if (XLEN == 32) begin : g_xlen32
            assign load_value = word_ext;
        end else begin : g_xlen_wide
            assign load_value = {{(XLEN-32){fill}}, word_ext};
        end
    endgenerate

endmodule

// File: rtl/write_back_unit.sv
// Write-back stage: result selection, load alignment and a DEPTH-entry retire FIFO.
// Optional macro WB_INSTRET_EN adds a 64-bit retired-instruction counter output.
module write_back_unit
    import write_back_unit_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned DEPTH = 2
)
(
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_4,
    input  logic [XLEN-1:0] result,
    input  logic [XLEN-1:0] load_data,
    input  logic [1:0]      byte_offset,
    input  load_size_t      load_size,
    input  logic            load_unsigned,
    input  logic [4:0]      rd,
    input  write_back_op_t  write_back_ctrl,
    input  logic            out_ready,
    output reg_file_op_t    register_op,
    output logic [4:0]      register_addr,
    output logic [XLEN-1:0] register_data,
    output logic            out_valid
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]     instret
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [XLEN-1:0]  data_q [DEPTH];
    logic [4:0]       addr_q [DEPTH];
    logic [DEPTH-1:0] wen_q;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic            push;
    logic            pop;
    logic [XLEN-1:0] load_value;
    logic [XLEN-1:0] push_data;
    logic            push_wen;

    load_align #(.XLEN(XLEN)) u_load_align (
        .load_data     (load_data),
        .byte_offset   (byte_offset),
        .load_size     (load_size),
        .load_unsigned (load_unsigned),
        .load_value    (load_value)
    );

    assign out_valid = (count_q != '0);
    assign in_ready  = (count_q < FULL);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        push_data = '0;
        push_wen  = 1'b0;
        case (write_back_ctrl)
            WRITE_BACK_PC: begin
                push_data = pc_4;
                push_wen  = 1'b1;
            end
            WRITE_BACK_OUT: begin
                push_data = result;
                push_wen  = 1'b1;
            end
            WRITE_BACK_LOAD: begin
                push_data = load_value;
                push_wen  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only observable while count covers them.
    always_ff @(posedge clock) begin
        if (push && !flush && !reset) begin
            data_q[wptr_q] <= push_data;
            addr_q[wptr_q] <= rd;
            wen_q[wptr_q]  <= push_wen;
        end
    end

    assign register_addr = out_valid ? addr_q[rptr_q] : '0;
    assign register_data = out_valid ? data_q[rptr_q] : '0;
    assign register_op   = (out_valid && wen_q[rptr_q] && (addr_q[rptr_q] != 5'd0))
                           ? WRITE_REG_DATA : NO_REG_DATA;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            instret_q <= '0;
        end else if (!flush && pop) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_write_back_unit.sv
// Scoreboard bench for write_back_unit; define WB_INSTRET_EN to also check the retire counter.
module tb_write_back_unit;
    import write_back_unit_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic [XLEN-1:0] pc_4;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] load_data;
    logic [1:0]      byte_offset;
    load_size_t      load_size;
    logic            load_unsigned;
    logic [4:0]      rd;
    write_back_op_t  write_back_ctrl;
    logic            out_ready;
    reg_file_op_t    register_op;
    logic [4:0]      register_addr;
    logic [XLEN-1:0] register_data;
    logic            out_valid;
`ifdef WB_INSTRET_EN
    logic [63:0]     instret;
`endif

    typedef struct {
        reg_file_op_t    op;
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] exp_instret = '0;
    int          tests = 0;
    int          fails = 0;

    always #5 clock = ~clock;

    write_back_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .flush           (flush),
        .pc_4            (pc_4),
        .result          (result),
        .load_data       (load_data),
        .byte_offset     (byte_offset),
        .load_size       (load_size),
        .load_unsigned   (load_unsigned),
        .rd              (rd),
        .write_back_ctrl (write_back_ctrl),
        .out_ready       (out_ready),
        .register_op     (register_op),
        .register_addr   (register_addr),
        .register_data   (register_data),
        .out_valid       (out_valid)
`ifdef WB_INSTRET_EN
        ,
        .instret         (instret)
`endif
    );

    // Reference for one pushed instruction, built from the current inputs by shifting and masking.
    function automatic exp_t model();
        exp_t            e;
        logic [XLEN-1:0] sh;
        logic            wr;
        wr     = 1'b1;
        e.addr = rd;
        e.data = '0;
        case (write_back_ctrl)
            WRITE_BACK_PC:  e.data = pc_4;
            WRITE_BACK_OUT: e.data = result;
            WRITE_BACK_LOAD: begin
                if (load_size == LOAD_BYTE) begin
                    sh = load_data >> (byte_offset * 8);
                    if (!load_unsigned && sh[7]) e.data = sh | 32'hFFFF_FF00;
                    else                         e.data = sh & 32'h0000_00FF;
                end else if (load_size == LOAD_HALF) begin
                    sh = byte_offset[1] ? (load_data >> 16) : load_data;
                    if (!load_unsigned && sh[15]) e.data = sh | 32'hFFFF_0000;
                    else                          e.data = sh & 32'h0000_FFFF;
                end else begin
                    e.data = load_data;
                end
            end
            default: wr = 1'b0;
        endcase
        e.op = (wr && rd != 5'd0) ? WRITE_REG_DATA : NO_REG_DATA;
        return e;
    endfunction

    task automatic set_in(input write_back_op_t c, input logic [4:0] r, input logic [31:0] res,
                          input logic [31:0] pc, input logic [31:0] ld, input logic [1:0] off,
                          input load_size_t sz, input logic u);
        write_back_ctrl = c;
        rd              = r;
        result          = res;
        pc_4            = pc;
        load_data       = ld;
        byte_offset     = off;
        load_size       = sz;
        load_unsigned   = u;
    endtask

    // Advance one clock and update the scoreboard with what the edge should do.
    task automatic advance();
        bit   acc;
        bit   deq;
        exp_t e;
        acc = in_valid && (sb.size() < DEPTH);
        deq = (sb.size() != 0) && out_ready;
        e   = model();
        @(posedge clock);
        if (reset) begin
            sb.delete();
            exp_instret = '0;
        end else if (flush) begin
            sb.delete();
        end else begin
            if (deq) begin
                sb.delete(0);
                exp_instret = exp_instret + 64'd1;
            end
            if (acc) sb.push_back(e);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        advance();
        reset = 1'b0;
        @(negedge clock);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (register_op !== NO_REG_DATA) begin fails++; $display("FAIL reset_op: got %0d want %0d", register_op, NO_REG_DATA); end
        tests++; if (register_addr !== 5'd0) begin fails++; $display("FAIL reset_addr: got %0d want 0", register_addr); end
        tests++; if (register_data !== 32'd0) begin fails++; $display("FAIL reset_data: got %h want 0", register_data); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef WB_INSTRET_EN
        tests++; if (instret !== 64'd0) begin fails++; $display("FAIL reset_instret: got %0d want 0", instret); end
`endif
        advance();
    endtask

    task automatic test_out();
        set_in(WRITE_BACK_OUT, 5'd5, 32'h1234, 32'h0, 32'h0, 2'd0, LOAD_WORD, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL out_in_ready: got %b want 1", in_ready); end
        advance();
        in_valid = 1'b0;
        @(negedge clock);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL out_valid: got %b want 1", out_valid); end
        tests++; if (register_op !== WRITE_REG_DATA) begin fails++; $display("FAIL out_op: got %0d want %0d", register_op, WRITE_REG_DATA); end
        tests++; if (register_addr !== 5'd5) begin fails++; $display("FAIL out_addr: got %0d want 5", register_addr); end
        tests++; if (register_data !== 32'h0000_1234) begin fails++; $display("FAIL out_data: got %h want 00001234", register_data); end
        advance();
        @(negedge clock);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL out_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_load();
        load_size_t  sz  [5] = '{LOAD_BYTE, LOAD_BYTE, LOAD_HALF, LOAD_BYTE, LOAD_HALF};
        logic [1:0]  off [5] = '{2'd2, 2'd2, 2'd3, 2'd1, 2'd0};
        logic        uns [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [31:0] want[5] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_007F, 32'h0000_7F01};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(WRITE_BACK_LOAD, 5'd7, 32'h0, 32'h0, 32'h80FF_7F01, off[i], sz[i], uns[i]);
            in_valid = 1'b1;
            advance();
            in_valid = 1'b0;
            @(negedge clock);
            tests++;
            if (register_data !== want[i] || out_valid !== 1'b1 || register_op !== WRITE_REG_DATA) begin
                fails++;
                $display("FAIL load_%0d: got v=%b op=%0d data=%h want v=1 op=1 data=%h", i, out_valid, register_op, register_data, want[i]);
            end
            advance();
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_in(write_back_op_t'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom(), $urandom(),
                   $urandom(), 2'($urandom_range(0, 3)), load_size_t'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            in_valid = (i < 13);
            @(negedge clock);
            tests++; if (in_ready !== (sb.size() < DEPTH)) begin fails++; $display("FAIL b2b_in_ready_%0d: got %b want %b", i, in_ready, sb.size() < DEPTH); end
            tests++; if (out_valid !== (sb.size() != 0)) begin fails++; $display("FAIL b2b_valid_%0d: got %b want %b", i, out_valid, sb.size() != 0); end
            if (sb.size() != 0) begin
                tests++;
                if (register_op !== sb[0].op || register_addr !== sb[0].addr || register_data !== sb[0].data) begin
                    fails++;
                    $display("FAIL b2b_head_%0d: got op=%0d rd=%0d data=%h want op=%0d rd=%0d data=%h",
                             i, register_op, register_addr, register_data, sb[0].op, sb[0].addr, sb[0].data);
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(WRITE_BACK_OUT, 5'(10 + i), 32'hA0 + i, 32'h0, 32'h0, 2'd0, LOAD_WORD, 1'b0);
            in_valid = 1'b1;
            @(negedge clock);
            tests++; if (in_ready !== (i < 2)) begin fails++; $display("FAIL bp_in_ready_%0d: got %b want %b", i, in_ready, i < 2); end
            advance();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (i < 2) begin
                tests++;
                if (out_valid !== 1'b1 || register_addr !== 5'(10 + i) || register_data !== 32'hA0 + i
                    || register_data !== sb[0].data) begin
                    fails++;
                    $display("FAIL bp_drain_%0d: got v=%b rd=%0d data=%h want v=1 rd=%0d data=%h",
                             i, out_valid, register_addr, register_data, 10 + i, 32'hA0 + i);
                end
            end else begin
                tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty: got %b want 0", out_valid); end
            end
            advance();
        end
    endtask

    task automatic test_rd0();
        set_in(WRITE_BACK_PC, 5'd0, 32'h0, 32'h104, 32'h0, 2'd0, LOAD_WORD, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        advance();
        in_valid = 1'b0;
        @(negedge clock);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rd0_valid: got %b want 1", out_valid); end
        tests++; if (register_op !== NO_REG_DATA) begin fails++; $display("FAIL rd0_op: got %0d want %0d", register_op, NO_REG_DATA); end
        advance();
        @(negedge clock);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rd0_popped: got %b want 0", out_valid); end
`ifdef WB_INSTRET_EN
        tests++; if (instret !== exp_instret) begin fails++; $display("FAIL rd0_instret: got %0d want %0d", instret, exp_instret); end
`endif
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_in(WRITE_BACK_OUT, 5'(3 + i), 32'h55 + i, 32'h0, 32'h0, 2'd0, LOAD_WORD, 1'b0);
            advance();
        end
        @(negedge clock);
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_full: got in_ready=%b want 0", in_ready); end
        flush = 1'b1;
        advance();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        tests++;
        if (out_valid !== 1'b0 || register_op !== NO_REG_DATA || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_empty: got v=%b op=%0d rdy=%b want v=0 op=0 rdy=1", out_valid, register_op, in_ready);
        end
`ifdef WB_INSTRET_EN
        tests++; if (instret !== exp_instret) begin fails++; $display("FAIL flush_instret: got %0d want %0d", instret, exp_instret); end
`endif
        out_ready = 1'b1;
        advance();
        @(negedge clock);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_stays_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_in(WRITE_BACK_OUT, 5'd9, 32'hDEAD, 32'h0, 32'h0, 2'd0, LOAD_WORD, 1'b0);
        advance();
        in_valid = 1'b0;
        @(negedge clock);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rst_mid_buffered: got %b want 1", out_valid); end
        reset     = 1'b1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        advance();
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        tests++;
        if (out_valid !== 1'b0 || register_op !== NO_REG_DATA || register_addr !== 5'd0 || register_data !== 32'd0) begin
            fails++;
            $display("FAIL rst_mid_outputs: got v=%b op=%0d rd=%0d data=%h want all zero", out_valid, register_op, register_addr, register_data);
        end
`ifdef WB_INSTRET_EN
        tests++; if (instret !== 64'd0) begin fails++; $display("FAIL rst_mid_instret: got %0d want 0", instret); end
`endif
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_in(NO_WRITE_BACK, 5'd0, 32'h0, 32'h0, 32'h0, 2'd0, LOAD_WORD, 1'b0);
        test_reset();
        test_out();
        test_load();
        test_back_to_back();
        test_backpressure();
        test_rd0();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/write_back_unit.md
WRITE_BACK_UNIT -- requirements
Module: write_back_unit

Interface
REQ-001 Parameter XLEN, default 32; data path width.
REQ-002 Parameter DEPTH, default 2; result-buffer entries, power of two, at least 2.
REQ-003 clock  input  1  sole clock; all state updates on posedge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream presents a retiring instruction.
REQ-006 in_ready  output  1  unit can accept an instruction this cycle.
REQ-007 flush  input  1  discard all buffered entries.
REQ-008 pc_4  input  XLEN  PC+4 for link writes.
REQ-009 result  input  XLEN  ALU or memory-stage result.
REQ-010 load_data  input  XLEN  raw aligned word from data memory.
REQ-011 byte_offset  input  2  load address bits [1:0].
REQ-012 load_size  input  load_size_t  LOAD_BYTE, LOAD_HALF or LOAD_WORD.
REQ-013 load_unsigned  input  1  zero-extend instead of sign-extend.
REQ-014 rd  input  5  destination register index.
REQ-015 write_back_ctrl  input  write_back_op_t  NO_WRITE_BACK, WRITE_BACK_PC, WRITE_BACK_OUT or WRITE_BACK_LOAD.
REQ-016 out_ready  input  1  register file accepts the head entry.
REQ-017 register_op  output  reg_file_op_t  WRITE_REG_DATA or NO_REG_DATA.
REQ-018 register_addr  output  5  destination index of the head entry.
REQ-019 register_data  output  XLEN  write data of the head entry.
REQ-020 out_valid  output  1  buffer non-empty.

Function
REQ-021 Accept on posedge when in_valid and in_ready; in_ready is 1 exactly when count < DEPTH, with no same-cycle pass-through when full.
REQ-022 Data select at push: PC -> pc_4; OUT -> result; LOAD -> extracted load; NO_WRITE_BACK or illegal -> 0 with write flag clear.
REQ-023 Load extraction: byte = load_data[8*byte_offset +: 8]; half = load_data[16*byte_offset[1] +: 16], ignoring byte_offset[0]; word ignores the offset; extend to XLEN by sign or zero per load_unsigned.
REQ-024 Buffer is a circular FIFO with read and write pointers wrapping modulo DEPTH and a count from 0 to DEPTH.
REQ-025 out_valid = (count != 0); a pushed entry is visible at the outputs in the cycle after acceptance, giving 1-cycle latency.
REQ-026 register_op = WRITE_REG_DATA only when out_valid, the head write flag is set and head rd != 0; otherwise NO_REG_DATA.
REQ-027 register_addr and register_data show head fields when out_valid, else 0.
REQ-028 Pop on posedge when out_valid and out_ready; an entry with NO_REG_DATA still pops under the same rule.
REQ-029 Simultaneous push and pop: count is unchanged and both pointers advance.
REQ-030 flush: count and pointers go to 0 on the next posedge, and flush overrides push and pop in that cycle.

Reset
REQ-031 With reset high at posedge: count = 0, pointers = 0, out_valid = 0, register_op = NO_REG_DATA, register_addr = 0, register_data = 0, in_ready = 1 in the following cycle, and the retire counter clears.
REQ-032 reset mid-operation discards buffered entries with no register write issued, and it overrides flush, push and pop.

Configuration
REQ-033 Macro WB_INSTRET_EN defined: add output instret, 64 bits; increment by 1 on every pop, wrap from 2^64-1 to 0, hold on flush, clear on reset.
REQ-034 WB_INSTRET_EN undefined: no instret port and no counter logic.

Structure
REQ-035 write_back_op_t (extended with WRITE_BACK_LOAD), load_size_t, reg_file_op_t and XLEN default live in the shared params package.
REQ-036 Load extraction is a combinational sub-module load_align; the FIFO stays inline.

Verification
REQ-037 Scenario 1: push OUT, result=0x1234, rd=5, out_ready=1 -> next cycle register_op=WRITE_REG_DATA, addr=5, data=0x00001234; then empty.
REQ-038 Scenario 2: push LOAD, load_data=0x80FF7F01, byte, offset 2, signed -> data=0xFFFFFFFF; same with unsigned -> 0x000000FF; half, offset 3, signed -> 0xFFFF80FF.
REQ-039 Scenario 3: out_ready=0 with three pushes attempted back-to-back -> two accepted, in_ready=0 on the third; raise out_ready -> entries drain in order, one per cycle.
REQ-040 Scenario 4: push PC with rd=0, pc_4=0x104 -> out_valid=1, register_op=NO_REG_DATA; pops, and instret increments (WB_INSTRET_EN).
REQ-041 Scenario 5: buffer full, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, nothing written.
REQ-042 Scenario 6: reset asserted while one entry is buffered -> next cycle all outputs 0/NO_REG_DATA and instret=0.
